e_x_eval: RTL and testbench

- Back end of the exponential path: consumes the magnitude y = x²/2 (8.24 unsigned) and the 4.28 original sample from the squaring pre-stage.
- Returns e^-y as 1.31 unsigned, plus the original sample as a passthrough tag.
- Method: range reduction y = k·ln2 + r, then shift-add evaluation of e^(ln2−r) via an internal ln(1+2^-i) ROM, then shift right by k+1.
- Multi-cycle FSM with valid/ready on both sides; one item in flight.

---
 rtl/e_x_eval.sv | 192 +++++++++++++++++++
 tb/tb_e_x_eval.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/e_x_eval.sv
// e_x_eval: e^-y as 1.31 from y = x^2/2 (8.24) by ln2 range reduction plus shift-add; orig_num rides along as a tag.
// Latency: 1 + (k+1) + ITERS + 1 cycles from acceptance to out_valid (27 for y=0, ITERS=24); 2 cycles on underflow.
// Backpressure: one item in flight; result held in DONE until out_ready, in_ready stays low until the next IDLE cycle.
// Optional feature: define E_X_UFLOW_FLAG_EN to add the uflow output flagging the underflow path.
module e_x_eval #(
  // Shift-add iterations; legal range 1..30 (the ROM holds 30 entries).
  parameter int ITERS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y,
  input  logic [31:0] orig_num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ex,
  output logic [31:0] orig_out
`ifdef E_X_UFLOW_FLAG_EN
  ,
  output logic        uflow
`endif
);

  // ln2 in 8.24, and 32*ln2: anything at or above it would need a shift of 32+ and reads as zero.
  localparam logic [31:0] LN2     = 32'h00B1_7218;
  localparam logic [31:0] UFLOW   = 32'h162E_4300;
  // 1.0 in the 2.31 product register, and 1.0 in the 1.31 output.
  localparam logic [32:0] P_ONE   = 33'h0_8000_0000;
  localparam logic [31:0] EX_ONE  = 32'h8000_0000;
  localparam logic [4:0]  ITERS_L = 5'(ITERS);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    ITER,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] resid;    // y minus the ln2 multiples taken so far
  logic [31:0] tag;      // orig_num of the item in flight
  logic [4:0]  k;        // number of ln2 multiples removed
  logic [31:0] s;        // exponent still to be built by the shift-add loop
  logic [32:0] p;        // running product, 2.31
  logic [4:0]  i;        // current iteration index, 1..ITERS

  logic [23:0] rom_val;
  logic [32:0] p_sum;
  logic [5:0]  shamt;
  logic [32:0] p_scaled;
  logic [31:0] result_next;

  // ln(1+2^-i) scaled by 2^24 and rounded; entry 1 is held at 67CC8F, one LSB under the rounded value.
  // From i=25 the scaled constant rounds to zero, so those steps always take the multiply.
  function automatic logic [23:0] ln_rom(input logic [4:0] idx);
    logic [23:0] v;
    v = 24'h000000;
    case (idx)
      5'd1:  v = 24'h67CC8F;
      5'd2:  v = 24'h391FF0;
      5'd3:  v = 24'h1E2707;
      5'd4:  v = 24'h0F8518;
      5'd5:  v = 24'h07E0A7;
      5'd6:  v = 24'h03F815;
      5'd7:  v = 24'h01FE03;
      5'd8:  v = 24'h00FF80;
      5'd9:  v = 24'h007FE0;
      5'd10: v = 24'h003FF8;
      5'd11: v = 24'h001FFE;
      5'd12: v = 24'h001000;
      5'd13: v = 24'h000800;
      5'd14: v = 24'h000400;
      5'd15: v = 24'h000200;
      5'd16: v = 24'h000100;
      5'd17: v = 24'h000080;
      5'd18: v = 24'h000040;
      5'd19: v = 24'h000020;
      5'd20: v = 24'h000010;
      5'd21: v = 24'h000008;
      5'd22: v = 24'h000004;
      5'd23: v = 24'h000002;
      5'd24: v = 24'h000001;
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

  // Datapath for one ITER step and for the final scale/clamp in SHIFT.
  always_comb begin
    rom_val     = ln_rom(i);
    p_sum       = p + (p >> i);
    shamt       = {1'b0, k} + 6'd1;
    p_scaled    = p >> shamt;
    result_next = (p_scaled > P_ONE) ? EX_ONE : p_scaled[31:0];
  end

  // Control FSM with registered handshake and result outputs; reset aborts any item in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ex        <= 32'h0;
      orig_out  <= 32'h0;
      resid     <= 32'h0;
      tag       <= 32'h0;
      k         <= 5'd0;
      s         <= 32'h0;
      p         <= 33'h0;
      i         <= 5'd0;
`ifdef E_X_UFLOW_FLAG_EN
      uflow     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            resid    <= y;
            tag      <= orig_num;
            k        <= 5'd0;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end
        end

        REDUCE: begin
          // resid only shrinks here, so the underflow test can only fire on the first cycle.
          if (resid >= UFLOW) begin
            ex        <= 32'h0;
            orig_out  <= tag;
            out_valid <= 1'b1;
`ifdef E_X_UFLOW_FLAG_EN
            uflow     <= 1'b1;
`endif
            state     <= DONE;
          end else if (resid >= LN2) begin
            resid <= resid - LN2;
            k     <= k + 5'd1;
          end else begin
            // e^-r = e^(ln2-r)/2, and ln2-r is positive, which the greedy loop needs.
            s     <= LN2 - resid;
            p     <= P_ONE;
            i     <= 5'd1;
            state <= ITER;
          end
        end

        ITER: begin
          if (s >= {8'd0, rom_val}) begin
            s <= s - {8'd0, rom_val};
            p <= p_sum;
          end
          i <= i + 5'd1;
          if (i == ITERS_L) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // Extra shift by one removes the factor 2 folded in by using ln2-r.
          ex        <= result_next;
          orig_out  <= tag;
          out_valid <= 1'b1;
`ifdef E_X_UFLOW_FLAG_EN
          uflow     <= 1'b0;
`endif
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef E_X_UFLOW_FLAG_EN
            uflow     <= 1'b0;
`endif
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_x_eval.sv
// Bench for e_x_eval: directed vectors with hand-computed results and latencies.
// Covers reset state, e^-0/e^-1/e^-2, underflow boundary, output backpressure and reset mid-computation.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_e_x_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic [31:0] orig_num;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ex;
  logic [31:0] orig_out;
`ifdef E_X_UFLOW_FLAG_EN
  logic        uflow;
  logic        last_uf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  e_x_eval #(.ITERS(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .orig_num (orig_num),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ex       (ex),
    .orig_out (orig_out)
`ifdef E_X_UFLOW_FLAG_EN
    ,
    .uflow    (uflow)
`endif
  );

  // Single comparison point: counts, and reports when |obs-exp| exceeds tol.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input int unsigned tol);
    logic [31:0] d;
    n_cmp++;
    d = (obs > exp) ? (obs - exp) : (exp - obs);
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // One full transaction: accept, wait for out_valid (bounded), capture, then handshake.
  // lat counts rising edges from the accepting edge (1) to the one that raises out_valid.
  task automatic run_item(input logic [31:0] yv, input logic [31:0] ov,
                          output logic [31:0] ex_o, output logic [31:0] orig_o, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1, 0);
    y        = yv;
    orig_num = ov;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1, 0);
    ex_o   = ex;
    orig_o = orig_out;
`ifdef E_X_UFLOW_FLAG_EN
    last_uf = uflow;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_ex;
    logic [31:0] r_orig;
    int          r_lat;
    int          w;
    int          stale;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y         = 32'h0;
    orig_num  = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
    chk("rst_ex",        ex,                 32'h0, 0);
    chk("rst_orig_out",  orig_out,           32'h0, 0);
`ifdef E_X_UFLOW_FLAG_EN
    chk("rst_uflow",     {31'd0, uflow},     32'd0, 0);
`endif
    reset = 1'b0;

    // e^-0: k=0, 1 REDUCE + 24 ITER + SHIFT -> 27 edges; clamped at 1.0.
    run_item(32'h0000_0000, 32'hF000_0000, r_ex, r_orig, r_lat);
    chk("y0_ex",   r_ex, 32'h8000_0000, 256);
    chk("y0_le1",  {31'd0, (r_ex <= 32'h8000_0000)}, 32'd1, 0);
    chk("y0_orig", r_orig, 32'hF000_0000, 0);
    chk("y0_lat",  r_lat, 32'd27, 0);
    chk("y0_idle", {31'd0, in_ready}, 32'd1, 0);

    // e^-1: k=1 -> 28 edges.
    run_item(32'h0100_0000, 32'h1234_5678, r_ex, r_orig, r_lat);
    chk("y1_ex",   r_ex, 32'h2F16_AC6C, 256);
    chk("y1_orig", r_orig, 32'h1234_5678, 0);
    chk("y1_lat",  r_lat, 32'd28, 0);

    // e^-2: k=2 -> 29 edges.
    run_item(32'h0200_0000, 32'h0ABC_DEF0, r_ex, r_orig, r_lat);
    chk("y2_ex",   r_ex, 32'h1152_AAA4, 256);
    chk("y2_orig", r_orig, 32'h0ABC_DEF0, 0);
    chk("y2_lat",  r_lat, 32'd29, 0);

    // y=24.0 is above 32*ln2: underflow path, two edges, zero result.
    run_item(32'h1800_0000, 32'hC000_0001, r_ex, r_orig, r_lat);
    chk("uf_ex",   r_ex, 32'h0, 0);
    chk("uf_orig", r_orig, 32'hC000_0001, 0);
    chk("uf_lat",  r_lat, 32'd2, 0);
`ifdef E_X_UFLOW_FLAG_EN
    chk("uf_flag", {31'd0, last_uf}, 32'd1, 0);
`endif

    // One LSB below 32*ln2: k=31, 32 REDUCE cycles -> 1+32+24+1 = 58 edges, p>>32 is 0.
    run_item(32'h162E_42FF, 32'h0000_0007, r_ex, r_orig, r_lat);
    chk("nuf_ex",   r_ex, 32'h0, 0);
    chk("nuf_lat",  r_lat, 32'd58, 0);
`ifdef E_X_UFLOW_FLAG_EN
    chk("nuf_flag", {31'd0, last_uf}, 32'd0, 0);
`endif

    // Backpressure: hold out_ready low for 10 cycles with a competing input pending.
    y        = 32'h0100_0000;
    orig_num = 32'h55AA_55AA;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 1;
    while (!out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_valid", {31'd0, out_valid}, 32'd1, 0);
    y        = 32'h0200_0000;
    orig_num = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_ex",       ex, 32'h2F16_AC6C, 256);
      chk("bp_orig",     orig_out, 32'h55AA_55AA, 0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0, 0);
      chk("bp_out_vld",  {31'd0, out_valid}, 32'd1, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_in_ready",  {31'd0, in_ready},  32'd1, 0);
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0, 0);
    in_valid = 1'b0;

    // Reset while in ITER: item discarded, outputs back to reset values.
    y        = 32'h0000_0000;
    orig_num = 32'h1111_1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0, 0);
    chk("mr_in_ready",  {31'd0, in_ready},  32'd1, 0);
    chk("mr_ex",        ex,                 32'h0, 0);
    chk("mr_orig",      orig_out,           32'h0, 0);
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("mr_no_stale", stale, 32'd0, 0);
    run_item(32'h0200_0000, 32'h2222_2222, r_ex, r_orig, r_lat);
    chk("mr_y2_ex",   r_ex, 32'h1152_AAA4, 256);
    chk("mr_y2_orig", r_orig, 32'h2222_2222, 0);
    chk("mr_y2_lat",  r_lat, 32'd29, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
